// File: rtl/boreal_cordic_pkg.sv
// Shared constants, state encoding and angle-table helpers for the CORDIC engine.
package boreal_cordic_pkg;

    localparam logic MODE_VEC = 1'b0;
    localparam logic MODE_ROT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_GAIN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // atan(2^-i) in Q2.30
    localparam logic [31:0] ATAN_Q30 [0:31] = '{
        32'd843314857, 32'd497837829, 32'd263043837, 32'd133525159,
        32'd67021687,  32'd33543516,  32'd16775851,  32'd8388437,
        32'd4194283,   32'd2097149,   32'd1048576,   32'd524288,
        32'd262144,    32'd131072,    32'd65536,     32'd32768,
        32'd16384,     32'd8192,      32'd4096,      32'd2048,
        32'd1024,      32'd512,       32'd256,       32'd128,
        32'd64,        32'd32,        32'd16,        32'd8,
        32'd4,         32'd2,         32'd1,         32'd0
    };

    // Unsigned right shift with round-half-up; sh must be >= 1.
    function automatic logic [63:0] f_round_shift(input logic [63:0] v, input int sh);
        return (v + (64'd1 << (sh - 1))) >> sh;
    endfunction

    // Angles are Q(aw-3) fraction bits, so Q30 values shift by 33-aw.
    function automatic logic [63:0] f_pi(input int aw);
        return f_round_shift({32'd0, ATAN_Q30[0]} << 2, 33 - aw);
    endfunction

    function automatic logic [63:0] f_half_pi(input int aw);
        return f_round_shift({32'd0, ATAN_Q30[0]} << 1, 33 - aw);
    endfunction

    function automatic logic [63:0] f_atan_q(input logic [4:0] idx, input int aw);
        return f_round_shift({32'd0, ATAN_Q30[idx]}, 33 - aw);
    endfunction

endpackage

// File: rtl/boreal_cordic_prerot.sv
// Quadrant pre-rotation by +/-90 degrees so the iterative core only sees
// angles inside its convergence range.
module boreal_cordic_prerot
    import boreal_cordic_pkg::*;
#(
    parameter int IW      = 22,
    parameter int ANGLE_W = 16
) (
    input  logic                      i_mode,
    input  logic signed [IW-1:0]      i_x,
    input  logic signed [IW-1:0]      i_y,
    input  logic signed [ANGLE_W-1:0] i_z,
    output logic signed [IW-1:0]      o_x,
    output logic signed [IW-1:0]      o_y,
    output logic signed [ANGLE_W-1:0] o_z
);

    localparam logic signed [ANGLE_W-1:0] HALF_PI     = ANGLE_W'(f_half_pi(ANGLE_W));
    localparam logic signed [ANGLE_W-1:0] NEG_HALF_PI = -HALF_PI;

    // Vectoring folds the left half-plane onto the right; rotation folds
    // target angles beyond +/-pi/2 back inside.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (i_mode == MODE_VEC) begin
            if (i_x < 0) begin
                if (i_y >= 0) begin
                    o_x = i_y;
                    o_y = -i_x;
                    o_z = i_z + HALF_PI;
                end else begin
                    o_x = -i_y;
                    o_y = i_x;
                    o_z = i_z - HALF_PI;
                end
            end
        end else begin
            if (i_z > HALF_PI) begin
                o_x = -i_y;
                o_y = i_x;
                o_z = i_z - HALF_PI;
            end else if (i_z < NEG_HALF_PI) begin
                o_x = i_y;
                o_y = -i_x;
                o_z = i_z + HALF_PI;
            end
        end
    end

endmodule

// File: rtl/boreal_cordic_engine.sv
// Iterative shift-add CORDIC (vectoring / rotation) with CSD gain
// compensation, output saturation and valid/ready on both sides.
module boreal_cordic_engine
    import boreal_cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16,
    parameter int ITER    = 16,
    parameter int GUARD_W = 4,
    parameter int TAG_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic signed [DATA_W-1:0]  in_x,
    input  logic signed [DATA_W-1:0]  in_y,
    input  logic signed [ANGLE_W-1:0] in_z,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_x,
    output logic signed [DATA_W-1:0]  out_y,
    output logic signed [ANGLE_W-1:0] out_z,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_sat
);

    // Two extra integer bits cover CORDIC gain, sqrt2 growth and -min negation.
    localparam int IW   = DATA_W + GUARD_W + 2;
    // Gain product x*(256+64-8-1) needs ~10 more bits; one spare for rounding.
    localparam int GW   = IW + 11;
    localparam int IT_W = $clog2(ANGLE_W + 1);
    localparam int RSH  = 9 + GUARD_W;
    localparam logic [IT_W-1:0]      LAST_IT = IT_W'(ITER - 1);
    localparam logic signed [GW-1:0] SMAX = {{(GW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [GW-1:0] SMIN = {{(GW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [GW-1:0] RND  = GW'(1) <<< (RSH - 1);

    // Scale by 2^-1+2^-3-2^-6-2^-9 = 311/512, drop guard bits with
    // round-half-up, clamp to DATA_W. Returns {clamped, value}.
    function automatic logic [DATA_W:0] f_gain(input logic signed [IW-1:0] v);
        logic signed [GW-1:0] e;
        logic signed [GW-1:0] s;
        logic signed [GW-1:0] r;
        e = GW'(v);
        s = (e <<< 8) + (e <<< 6) - (e <<< 3) - e;
        r = (s + RND) >>> RSH;
        if (r > SMAX) return {1'b1, SMAX[DATA_W-1:0]};
        if (r < SMIN) return {1'b1, SMIN[DATA_W-1:0]};
        return {1'b0, r[DATA_W-1:0]};
    endfunction

    state_t                    r_state, w_next;
    logic                      r_mode, r_vzero;
    logic signed [IW-1:0]      r_x, r_y;
    logic signed [ANGLE_W-1:0] r_z;
    logic [IT_W-1:0]           r_iter;
    logic [TAG_W-1:0]          r_tag;

    logic signed [IW-1:0]      w_xin, w_yin, w_px, w_py, w_xs, w_ys;
    logic signed [ANGLE_W-1:0] w_pz, w_atan;
    logic                      w_accept, w_ccw, w_last;
    logic [DATA_W:0]           w_gx, w_gy;

    assign w_xin = {{2{in_x[DATA_W-1]}}, in_x, {GUARD_W{1'b0}}};
    assign w_yin = {{2{in_y[DATA_W-1]}}, in_y, {GUARD_W{1'b0}}};

    boreal_cordic_prerot #(
        .IW      (IW),
        .ANGLE_W (ANGLE_W)
    ) u_prerot (
        .i_mode (in_mode),
        .i_x    (w_xin),
        .i_y    (w_yin),
        .i_z    (in_z),
        .o_x    (w_px),
        .o_y    (w_py),
        .o_z    (w_pz)
    );

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_iter == LAST_IT);
    assign w_xs     = r_x >>> r_iter;
    assign w_ys     = r_y >>> r_iter;
    assign w_atan   = ANGLE_W'(f_atan_q(5'(r_iter), ANGLE_W));
    // Counter-clockwise step: vectoring with y<0, or rotation with z>=0.
    assign w_ccw    = (r_mode == MODE_VEC) ? r_y[IW-1] : ~r_z[ANGLE_W-1];
    assign w_gx     = f_gain(r_x);
    assign w_gy     = f_gain(r_y);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs; HOLD can hand over straight to a new job
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_ITER;
            end
            ST_ITER: if (w_last) w_next = ST_GAIN;
            ST_GAIN: w_next = ST_HOLD;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_next = in_valid ? ST_ITER : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, one micro-rotation per ITER cycle, result register in GAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MODE_VEC;
            r_vzero <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_tag   <= '0;
            out_x   <= '0;
            out_y   <= '0;
            out_z   <= '0;
            out_tag <= '0;
            out_sat <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= in_mode;
            r_x     <= w_px;
            r_y     <= w_py;
            r_z     <= w_pz;
            r_tag   <= in_tag;
            r_iter  <= '0;
            // (0,0) has no angle: freeze z so the result is just the offset
            r_vzero <= (in_mode == MODE_VEC) && (in_x == '0) && (in_y == '0);
        end else if (r_state == ST_ITER) begin
            r_iter <= r_iter + 1'b1;
            if (w_ccw) begin
                r_x <= r_x - w_ys;
                r_y <= r_y + w_xs;
                if (!r_vzero) r_z <= r_z - w_atan;
            end else begin
                r_x <= r_x + w_ys;
                r_y <= r_y - w_xs;
                if (!r_vzero) r_z <= r_z + w_atan;
            end
        end else if (r_state == ST_GAIN) begin
            out_x   <= w_gx[DATA_W-1:0];
            out_y   <= w_gy[DATA_W-1:0];
            out_sat <= w_gx[DATA_W] | w_gy[DATA_W];
            out_z   <= r_z;
            out_tag <= r_tag;
        end
    end

endmodule

// File: tb/tb_boreal_cordic_engine.sv
// Scoreboard bench for boreal_cordic_engine: directed jobs push expected
// results; an independent monitor pops and compares on each output handshake.
module tb_boreal_cordic_engine;

    localparam logic VEC = 1'b0;
    localparam logic ROT = 1'b1;
    localparam int   LAT = 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_mode;
    logic signed [15:0] in_x, in_y, in_z;
    logic [3:0]         in_tag;
    logic               out_valid, out_ready;
    logic signed [15:0] out_x, out_y, out_z;
    logic [3:0]         out_tag;
    logic               out_sat;

    typedef struct {
        int         x, y, z, tx, ty, tz;
        logic [3:0] tag;
        logic       sat;
        int         vcyc;
        bit         lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   prev_ov;
    exp_t me;
    int   waited;

    boreal_cordic_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d) at cycle %0d", nm, act, exp, tol, cyc);
        end
    endtask

    // Monitor: latency on rising out_valid, field compare on each handshake
    initial begin
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && !prev_ov && sbq.size() > 0 && sbq[0].lat)
                chk("latency", cyc, sbq[0].vcyc, 0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0, 0);
                end else begin
                    me = sbq.pop_front();
                    chk("out_x", int'(out_x), me.x, me.tx);
                    chk("out_y", int'(out_y), me.y, me.ty);
                    if (me.tz >= 0) chk("out_z", int'(out_z), me.z, me.tz);
                    chk("out_tag", int'(out_tag), int'(me.tag), 0);
                    chk("out_sat", int'(out_sat), int'(me.sat), 0);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic mode, input int x, input int y, input int z,
                        input logic [3:0] tag, input int ex, input int ey, input int ez,
                        input int tx, input int ty, input int tz, input logic esat,
                        input logic ordy, input bit push, output int n);
        exp_t e;
        n = 0;
        @(negedge clk);
        in_mode   = mode;
        in_x      = 16'(x);
        in_y      = 16'(y);
        in_z      = 16'(z);
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = ordy;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1, 0);
        end else if (push) begin
            e.x = ex; e.y = ey; e.z = ez; e.tx = tx; e.ty = ty; e.tz = tz;
            e.tag = tag; e.sat = esat; e.vcyc = cyc + LAT; e.lat = 1'b1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = VEC; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_out_x", int'(out_x), 0, 0);
        chk("rst_out_z", int'(out_z), 0, 0);
        chk("rst_out_tag", int'(out_tag), 0, 0);
        chk("rst_out_sat", int'(out_sat), 0, 0);

        // Vectoring: first quadrant, +/-pi boundary, small negative y, saturation, zero vector, wrap
        send(VEC, 1000, 1000, 0, 4'd1, 1414, 0, 6434, 3, 3, 4, 1'b0, 1'b1, 1'b1, waited); drain();
        send(VEC, -1000, 0, 0, 4'd2, 1000, 0, 25736, 2, 3, 4, 1'b0, 1'b1, 1'b1, waited); drain();
        send(VEC, -1000, -1, 0, 4'd3, 1000, 0, -25728, 2, 3, 4, 1'b0, 1'b1, 1'b1, waited); drain();
        send(VEC, 32767, 32767, 0, 4'd6, 32767, 0, 6434, 0, 3, 4, 1'b1, 1'b1, 1'b1, waited); drain();
        send(VEC, -32768, 0, 0, 4'd7, 32767, 0, 25736, 0, 3, 4, 1'b1, 1'b1, 1'b1, waited); drain();
        send(VEC, 0, 0, 1000, 4'd8, 0, 0, 1000, 0, 0, 0, 1'b0, 1'b1, 1'b1, waited); drain();
        send(VEC, -1000, 0, 20000, 4'd9, 1000, 0, -19800, 2, 3, 4, 1'b0, 1'b1, 1'b1, waited); drain();
        // Rotation: +pi/2 in-range, -pi via pre-rotation
        send(ROT, 1000, 0, 12868, 4'd4, 0, 1000, 0, 3, 3, -1, 1'b0, 1'b1, 1'b1, waited); drain();
        send(ROT, 1000, 0, -25736, 4'd5, -1000, 0, 0, 3, 3, -1, 1'b0, 1'b1, 1'b1, waited); drain();

        // Backpressure: result held stable for 5 cycles, then back-to-back accept
        send(VEC, 3000, 4000, 0, 4'd10, 5000, 0, 7596, 3, 3, 4, 1'b0, 1'b0, 1'b1, waited);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", int'(out_valid), 1, 0);
            chk("hold_in_ready", int'(in_ready), 0, 0);
            chk("hold_tag", int'(out_tag), 10, 0);
            chk("hold_x", int'(out_x), 5000, 3);
        end
        send(ROT, 0, 1000, 0, 4'd11, 0, 1000, 0, 3, 3, -1, 1'b0, 1'b1, 1'b1, waited);
        chk("b2b_accept_wait", waited, 0, 0);
        chk("b2b_valid_drop", int'(out_valid), 0, 0);
        drain();

        // Reset while iterating: job aborted, outputs cleared, fresh job fine
        send(VEC, 1000, 1000, 0, 4'd12, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, waited);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_in_ready", int'(in_ready), 1, 0);
        chk("abort_out_y", int'(out_y), 0, 0);
        chk("abort_out_tag", int'(out_tag), 0, 0);
        repeat (25) @(negedge clk);
        send(VEC, 1000, 1000, 100, 4'd13, 1414, 0, 6534, 3, 3, 4, 1'b0, 1'b1, 1'b1, waited);
        drain();

        chk("scoreboard_empty", sbq.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
